i2s_tx_arbiter: RTL and testbench

- Shares one i2s_tx serializer between NUM_SRC stereo sample producers (synth voices, test tone, DMA playback).
- Sits between the sources and i2s_tx.
- Presents a stable left_chan/right_chan pair, advances on the i2s_tx load pulse, and prefetches the next frame from the arbitrated source into a one-frame stage.
- Handles underflow with either mute or hold.

---
 rtl/i2s_tx_arbiter_if.sv | 31 +++
 rtl/i2s_tx_arbiter.sv | 113 +++++++++++
 tb/tb_i2s_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_arbiter_if.sv
// Bundle between the stereo sample sources, the i2s_tx load strobe and the shared arbiter.
// The master side drives sources and load; the slave side is the arbiter.
interface i2s_tx_arbiter_if #(
    parameter int DATA_W  = 24,
    parameter int NUM_SRC = 2
);
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                      en;
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*DATA_W-1:0] src_left;
    logic [NUM_SRC*DATA_W-1:0] src_right;
    logic                      load;
    logic [DATA_W-1:0]         left_chan;
    logic [DATA_W-1:0]         right_chan;
    logic [AW-1:0]             active_src;
    logic                      front_live;
    logic [15:0]               underflow_cnt;

    modport master (
        output en, src_en, src_valid, src_left, src_right, load,
        input  src_ready, left_chan, right_chan, active_src, front_live, underflow_cnt
    );

    modport slave (
        input  en, src_en, src_valid, src_left, src_right, load,
        output src_ready, left_chan, right_chan, active_src, front_live, underflow_cnt
    );
endinterface

// File: rtl/i2s_tx_arbiter.sv
// Shares one i2s_tx serializer among NUM_SRC stereo sources: arbitrates into a one-frame
// STAGE, and on each load pulse moves STAGE into the FRONT register that feeds i2s_tx.
module i2s_tx_arbiter #(
    parameter int DATA_W         = 24,
    parameter int NUM_SRC        = 2,
    parameter int ARB_MODE       = 1,
    parameter int UNDERFLOW_MODE = 0
) (
    input logic              clk,
    input logic              rst_n,
    i2s_tx_arbiter_if.slave  bus
);
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_grant;
    logic [AW-1:0]      w_grant_idx;
    logic               w_any;
    logic               w_xfer;
    logic               w_take;

    logic [AW-1:0]      r_rr_ptr;
    logic               r_stage_valid;
    logic [AW-1:0]      r_stage_src;
    logic [DATA_W-1:0]  r_stage_l;
    logic [DATA_W-1:0]  r_stage_r;
    logic [DATA_W-1:0]  r_left;
    logic [DATA_W-1:0]  r_right;
    logic [AW-1:0]      r_active;
    logic               r_live;
    logic [15:0]        r_ucnt;

    function automatic int scan_idx(input int base, input int k);
        return (ARB_MODE == 1) ? (base + k) % NUM_SRC : k;
    endfunction

    assign w_elig = bus.en ? (bus.src_valid & bus.src_en) : '0;

    // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_any       = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_any && w_elig[scan_idx(int'(r_rr_ptr), k)]) begin
                w_any                                  = 1'b1;
                w_grant[scan_idx(int'(r_rr_ptr), k)]   = 1'b1;
                w_grant_idx                            = AW'(scan_idx(int'(r_rr_ptr), k));
            end
        end
    end

    // Ready is forced low while reset is asserted so no source sees a phantom accept.
    assign bus.src_ready = w_grant & {NUM_SRC{~r_stage_valid & rst_n}};
    assign w_xfer        = w_any & ~r_stage_valid;
    assign w_take        = bus.load & bus.en & r_stage_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_src   <= '0;
            r_rr_ptr      <= '0;
        end else if (w_take) begin
            r_stage_valid <= 1'b0;
        end else if (w_xfer) begin
            r_stage_valid <= 1'b1;
            r_stage_src   <= w_grant_idx;
            if (ARB_MODE == 1)
                r_rr_ptr <= (w_grant_idx == AW'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // NOTE: stage sample data is qualified by r_stage_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_stage_l <= bus.src_left[int'(w_grant_idx)*DATA_W +: DATA_W];
            r_stage_r <= bus.src_right[int'(w_grant_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left   <= '0;
            r_right  <= '0;
            r_active <= '0;
            r_live   <= 1'b0;
            r_ucnt   <= '0;
        end else if (bus.load) begin
            if (w_take) begin
                r_left   <= r_stage_l;
                r_right  <= r_stage_r;
                r_active <= r_stage_src;
                r_live   <= 1'b1;
            end else begin
                r_live <= 1'b0;
                if (UNDERFLOW_MODE == 0) begin
                    r_left  <= '0;
                    r_right <= '0;
                end
                // Disabled loads are filler by intent and are not counted as underflow.
                if (bus.en && r_ucnt != 16'hFFFF)
                    r_ucnt <= r_ucnt + 16'd1;
            end
        end
    end

    assign bus.left_chan     = r_left;
    assign bus.right_chan    = r_right;
    assign bus.active_src    = r_active;
    assign bus.front_live    = r_live;
    assign bus.underflow_cnt = r_ucnt;
endmodule

// File: tb/tb_i2s_tx_arbiter.sv
// Drives two arbiter configurations (round-robin/mute and fixed/hold) with shared stimulus
// and compares both against a frame-level reference model.
module tb_i2s_tx_arbiter;
    localparam int DW = 24;
    localparam int NS = 3;
    localparam int AW = 2;
    localparam int ARB_OF[2] = '{1, 0};
    localparam int UF_OF[2]  = '{0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              en;
    logic [NS-1:0]     src_en;
    logic [NS-1:0]     src_valid;
    logic [NS*DW-1:0]  src_left;
    logic [NS*DW-1:0]  src_right;
    logic              load;

    i2s_tx_arbiter_if #(.DATA_W(DW), .NUM_SRC(NS)) if_a ();
    i2s_tx_arbiter_if #(.DATA_W(DW), .NUM_SRC(NS)) if_b ();

    assign if_a.en = en;            assign if_b.en = en;
    assign if_a.src_en = src_en;    assign if_b.src_en = src_en;
    assign if_a.src_valid = src_valid; assign if_b.src_valid = src_valid;
    assign if_a.src_left = src_left;   assign if_b.src_left = src_left;
    assign if_a.src_right = src_right; assign if_b.src_right = src_right;
    assign if_a.load = load;        assign if_b.load = load;

    i2s_tx_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(1), .UNDERFLOW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    i2s_tx_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(0), .UNDERFLOW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int src; } frame_t;
    typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; logic [AW-1:0] src;
                     logic live; logic [15:0] ucnt; logic [NS-1:0] rdy; } obs_t;

    frame_t m_front[2];
    frame_t m_stage[2];
    bit     m_live[2];
    bit     m_full[2];
    int     m_ucnt[2];
    int     m_rr[2];

    int vec_cnt = 0;
    int err_cnt = 0;
    int since_load = 99;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t observe(input int k);
        obs_t o;
        if (k == 0) begin
            o.l = if_a.left_chan; o.r = if_a.right_chan; o.src = if_a.active_src;
            o.live = if_a.front_live; o.ucnt = if_a.underflow_cnt; o.rdy = if_a.src_ready;
        end else begin
            o.l = if_b.left_chan; o.r = if_b.right_chan; o.src = if_b.active_src;
            o.live = if_b.front_live; o.ucnt = if_b.underflow_cnt; o.rdy = if_b.src_ready;
        end
        return o;
    endfunction

    function automatic string nm(input int k, input string what);
        return $sformatf("%s.%s", (k == 0) ? "A" : "B", what);
    endfunction

    // The source the rules pick this cycle, or -1 when nobody is eligible.
    function automatic int model_pick(input int k);
        for (int n = 0; n < NS; n++) begin
            int i;
            i = (ARB_OF[k] == 1) ? (m_rr[k] + n) % NS : n;
            if (en && src_valid[i] && src_en[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] exp_ready(input int k);
        logic [NS-1:0] v;
        int g;
        v = '0;
        g = model_pick(k);
        if (rst_n && g >= 0 && !m_full[k]) v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_front[k] = '{l: '0, r: '0, src: 0};
            m_live[k] = 1'b0; m_full[k] = 1'b0; m_ucnt[k] = 0; m_rr[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int g;
            bit xfer;
            g = model_pick(k);
            xfer = (g >= 0) && !m_full[k];
            if (load) begin
                if (en && m_full[k]) begin
                    m_front[k] = m_stage[k];
                    m_live[k] = 1'b1;
                    m_full[k] = 1'b0;
                end else begin
                    m_live[k] = 1'b0;
                    if (UF_OF[k] == 0) begin m_front[k].l = '0; m_front[k].r = '0; end
                    if (en && m_ucnt[k] < 65535) m_ucnt[k]++;
                end
            end
            if (xfer) begin
                m_stage[k] = '{l: src_left[g*DW +: DW], r: src_right[g*DW +: DW], src: g};
                m_full[k] = 1'b1;
                if (ARB_OF[k] == 1) m_rr[k] = (g + 1) % NS;
            end
        end
    endtask

    task automatic check_front(input int k);
        obs_t o;
        o = observe(k);
        check(nm(k, "left_chan"), o.l, m_front[k].l);
        check(nm(k, "right_chan"), o.r, m_front[k].r);
        check(nm(k, "active_src"), o.src, m_front[k].src);
        check(nm(k, "front_live"), o.live, m_live[k]);
        check(nm(k, "underflow_cnt"), o.ucnt, m_ucnt[k]);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        obs_t o;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = observe(k);
            check(nm(k, "src_ready"), o.rdy, exp_ready(k));
        end
        @(posedge clk);
        model_step();
        since_load = load ? 0 : since_load + 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_front(k);
    endtask

    task automatic idle_inputs();
        en = 1'b1; src_en = '1; src_valid = '0; load = 1'b0;
        src_left = '0; src_right = '0;
    endtask

    task automatic set_src(input int i, input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        src_valid[i] = v;
        src_left[i*DW +: DW] = l;
        src_right[i*DW +: DW] = r;
    endtask

    // Asynchronous reset in the middle of a clock phase, checked before any edge arrives.
    task automatic do_reset();
        obs_t o;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = observe(k);
            check(nm(k, "rst.left"), o.l, 0);
            check(nm(k, "rst.right"), o.r, 0);
            check(nm(k, "rst.ucnt"), o.ucnt, 0);
            check(nm(k, "rst.ready"), o.rdy, 0);
            check(nm(k, "rst.live"), o.live, 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    int rr_seq[6] = '{0, 1, 0, 1, 0, 1};
    logic [DW-1:0] t4_a[3] = '{24'h123456, 24'h0, 24'h0};

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single frame from src0 reaches FRONT on the next load.
        set_src(0, 1'b1, 24'hE3E3E3, 24'h800001);
        #1 check("T2.ready_pulse", if_a.src_ready, 3'b001);
        tick();
        tick();
        set_src(0, 1'b0, 24'h0, 24'h0);
        load = 1'b1; tick(); load = 1'b0;
        check("T2.A.left", if_a.left_chan, 24'hE3E3E3);
        check("T2.A.right", if_a.right_chan, 24'h800001);
        check("T2.A.live", if_a.front_live, 1);
        check("T2.A.src", if_a.active_src, 0);
        set_src(0, 1'b1, 24'h111111, 24'h222222);

        // Reset with the front register holding live data and a source offering.
        do_reset();

        // Two sources always valid: rotation versus fixed priority.
        set_src(0, 1'b1, 24'hA00000, 24'hA00001);
        set_src(1, 1'b1, 24'hB00000, 24'hB00001);
        for (int n = 0; n < 6; n++) begin
            tick();
            load = 1'b1; tick(); load = 1'b0;
            check("T3.A.active_seq", if_a.active_src, rr_seq[n]);
            check("T3.B.active_seq", if_b.active_src, 0);
            tick();
        end
        check("T3.A.ucnt", if_a.underflow_cnt, 0);
        check("T3.B.ucnt", if_b.underflow_cnt, 0);

        // One frame then starvation: mute versus hold.
        do_reset();
        set_src(0, 1'b1, 24'h123456, 24'h654321);
        tick();
        set_src(0, 1'b0, 24'h0, 24'h0);
        for (int n = 0; n < 3; n++) begin
            load = 1'b1; tick(); load = 1'b0;
            check("T4.A.left", if_a.left_chan, t4_a[n]);
            check("T4.B.left", if_b.left_chan, 24'h123456);
            tick();
        end
        check("T4.A.ucnt", if_a.underflow_cnt, 2);
        check("T4.B.ucnt", if_b.underflow_cnt, 2);
        check("T4.A.live", if_a.front_live, 0);

        // Load and transfer in the same cycle, then counter saturation.
        do_reset();
        set_src(1, 1'b1, 24'hABCDEF, 24'hFEDCBA);
        load = 1'b1; tick(); load = 1'b0;
        set_src(1, 1'b0, 24'h0, 24'h0);
        check("T5.A.ucnt", if_a.underflow_cnt, 1);
        tick();
        load = 1'b1; tick(); load = 1'b0;
        check("T5.A.left", if_a.left_chan, 24'hABCDEF);
        check("T5.B.src", if_b.active_src, 1);
        force dut_a.r_ucnt = 16'hFFFF;
        force dut_b.r_ucnt = 16'hFFFF;
        m_ucnt[0] = 65535; m_ucnt[1] = 65535;
        tick();
        release dut_a.r_ucnt;
        release dut_b.r_ucnt;
        tick();
        load = 1'b1; tick(); load = 1'b0;
        check("T5.A.sat", if_a.underflow_cnt, 16'hFFFF);
        check("T5.B.sat", if_b.underflow_cnt, 16'hFFFF);

        // Disable with a frame staged: it survives and is sent after re-enable.
        do_reset();
        set_src(0, 1'b1, 24'h0A0B0C, 24'h0C0B0A);
        tick();
        en = 1'b0;
        #1 check("T6.ready_off", if_a.src_ready, 0);
        tick();
        load = 1'b1; tick(); load = 1'b0; tick();
        load = 1'b1; tick(); load = 1'b0; tick();
        check("T6.A.left", if_a.left_chan, 0);
        check("T6.A.ucnt", if_a.underflow_cnt, 0);
        en = 1'b1;
        tick();
        load = 1'b1; tick(); load = 1'b0;
        check("T6.A.left_retained", if_a.left_chan, 24'h0A0B0C);
        check("T6.B.live", if_b.front_live, 1);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 9) != 0);
            src_en = NS'($urandom_range(0, 7));
            for (int i = 0; i < NS; i++)
                set_src(i, ($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom));
            load = (since_load >= 2) && ($urandom_range(0, 2) == 0);
            tick();
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
